// File: rtl/encode_pkg.sv
// Shared widths, FSM state type and the byte-level Manchester code function
// for the 64->128-bit sequential encoder.
package encode_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CODE_W = 128;
    localparam int unsigned BYTES  = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SYM_W  = 2 * BYTE_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Data bit i lands in code[2i+1:2i]: 1 -> "10", 0 -> "01".
    function automatic logic [SYM_W-1:0] manch8(input logic [BYTE_W-1:0] b);
        logic [SYM_W-1:0] code;
        code = '0;
        for (int unsigned i = 0; i < BYTE_W; i++) begin
            code[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
        end
        return code;
    endfunction

endpackage

// File: rtl/manchester_byte_enc.sv
// Combinational 8->16 bit Manchester encoder for one data byte.
module manchester_byte_enc
    import encode_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_in,
    output logic [SYM_W-1:0]  code_out
);

    always_comb begin
        code_out = manch8(byte_in);
    end

endmodule

// File: rtl/top.sv
// Sequential 64->128-bit Manchester encoder: captures a word on start, encodes
// one byte per clock LSB byte first, then publishes the codeword with a done pulse.
module top
    import encode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              done,
    output logic [CODE_W-1:0] final_output
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CODE_W-1:0] work_q, work_d;
    logic [CODE_W-1:0] final_q, final_d;
    logic              done_q, done_d;

    logic [BYTE_W-1:0] byte_sel;
    logic [SYM_W-1:0]  byte_code;
    logic              last_byte;

    always_comb begin
        byte_sel = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                byte_sel = data_q[BYTE_W*i +: BYTE_W];
            end
        end
    end

    manchester_byte_enc u_byte_enc (
        .byte_in  (byte_sel),
        .code_out (byte_code)
    );

    assign last_byte = (cnt_q == CNT_W'(BYTES - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        work_d  = work_q;
        final_d = final_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = data_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        work_d[SYM_W*i +: SYM_W] = byte_code;
                    end
                end
                // The last slice is folded in on the same edge it is published.
                if (last_byte) begin
                    final_d = work_d;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            work_q  <= '0;
            final_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            work_q  <= work_d;
            final_q <= final_d;
            done_q  <= done_d;
        end
    end

    assign done         = done_q;
    assign final_output = final_q;

endmodule

// File: tb/tb_top.sv
// Directed scoreboard bench for the sequential Manchester encoder.
module tb_top;

    logic         clk;
    logic         reset;
    logic         start;
    logic [63:0]  data_in;
    logic         done;
    logic [127:0] final_output;

    int unsigned  total;
    int unsigned  bad;
    logic [127:0] sb[$];
    logic [127:0] held;

    top dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .data_in      (data_in),
        .done         (done),
        .final_output (final_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] ref_enc(input logic [63:0] d);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[2*i+1] = d[i];
            r[2*i]   = ~d[i];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents the word so the next posedge accepts it.
    task automatic issue(input logic [63:0] d, input logic [127:0] exp);
        start   = 1'b1;
        data_in = d;
        sb.push_back(exp);
    endtask

    // Walks negedges after the accepting edge; returns at the negedge where done is seen.
    task automatic await_done(input string tag, input int inj_k, input logic [63:0] inj_d);
        logic [127:0] exp;
        bit seen;
        seen = 0;
        for (int k = 0; k <= 12 && !seen; k++) begin
            @(negedge clk);
            start   = 1'b0;
            data_in = {$urandom, $urandom};
            if (done === 1'b1) begin
                seen = 1;
                check({tag, "_latency"}, 128'(k), 128'd8);
                if (sb.size() == 0) begin
                    check({tag, "_sb_empty"}, 128'd1, 128'd0);
                end else begin
                    exp = sb.pop_front();
                    check({tag, "_code"}, final_output, exp);
                    held = exp;
                end
            end else begin
                check({tag, "_held"}, final_output, held);
                if (k == inj_k) begin
                    start   = 1'b1;
                    data_in = inj_d;
                end
            end
        end
        if (!seen) check({tag, "_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic quiet(input string tag, input int n);
        int hits;
        hits = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start   = 1'b0;
            data_in = {$urandom, $urandom};
            if (done !== 1'b0 || final_output !== held) hits++;
        end
        check({tag, "_quiet"}, 128'(hits), 128'd0);
    endtask

    initial begin
        logic [63:0] rnd;
        total   = 0;
        bad     = 0;
        held    = '0;
        reset   = 1'b1;
        start   = 1'b1;
        data_in = 64'h0123456789ABCDEF;

        repeat (2) @(negedge clk);
        check("rst_done", 128'(done), 128'd0);
        check("rst_final", final_output, 128'h0);
        reset = 1'b0;
        start = 1'b0;
        quiet("post_rst", 10);

        issue(64'h123456789ABCDEF0, 128'h56595A6566696A9596999AA5A6A9AA55);
        await_done("vec1", -1, '0);
        issue(64'hFEDCBA9876543210, 128'hAAA9A6A59A9996956A6966655A595655);
        await_done("vec2", -1, '0);
        quiet("after_vec2", 3);

        issue(64'h0, {8{16'h5555}});
        await_done("zeros", -1, '0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, {8{16'hAAAA}});
        await_done("ones", -1, '0);
        issue(64'h8000_0000_0000_0001, 128'h9555_5555_5555_5555_5555_5555_5555_5556);
        await_done("edges", -1, '0);

        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            rnd = {$urandom, $urandom};
            issue(rnd, ref_enc(rnd));
            await_done("rand", -1, '0);
        end

        @(negedge clk);
        issue(64'hDEADBEEF_CAFEF00D, ref_enc(64'hDEADBEEF_CAFEF00D));
        await_done("busy", 3, 64'h1111_2222_3333_4444);
        quiet("busy_single", 12);

        issue(64'hA5A5_5A5A_0F0F_F0F0, ref_enc(64'hA5A5_5A5A_0F0F_F0F0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_done", 128'(done), 128'd0);
        check("abort_final", final_output, 128'h0);
        void'(sb.pop_back());
        held = '0;
        quiet("abort_idle", 12);

        issue(64'h0F1E_2D3C_4B5A_6978, ref_enc(64'h0F1E_2D3C_4B5A_6978));
        await_done("post_abort", -1, '0);
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
